// File: rtl/cpu_w_context_stack.sv
// Working register W plus Z/DC/C flags, with a DEPTH-entry shadow stack
// that saves and restores the {flags, W} context around interrupts.
module cpu_w_context_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int WRAP  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_w,
    input  logic [WIDTH-1:0]             alu_to_w,
    input  logic                         load_flags,
    input  logic [2:0]                   flags_in,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr_err,
    output logic [WIDTH-1:0]             w_accumulator_out,
    output logic [2:0]                   flags_out,
    output logic [$clog2(DEPTH+1)-1:0]   stack_count,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int CTX = WIDTH + 3;

    logic [WIDTH-1:0] w_q, w_d;
    logic [2:0]       flags_q, flags_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [CTX-1:0]   stk_q [DEPTH];
    logic [CTX-1:0]   stk_d [DEPTH];

    logic [CTX-1:0]   ctx;
    logic [CTX-1:0]   top;
    logic             empty, full;
    logic             exch, do_pop, do_push;
    logic             ev_ovf, ev_unf;

    always_comb begin
        ctx   = {flags_q, w_q};
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        top   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == count_q) top = stk_q[i];
        end

        exch    = push && pop && !empty;
        do_pop  = pop && !push && !empty;
        do_push = push && (!pop || empty);
        ev_ovf  = do_push && full;
        ev_unf  = pop && !push && empty;

        w_d     = w_q;
        flags_d = flags_q;
        count_d = count_q;
        stk_d   = stk_q;

        // A successful pop or exchange owns W/flags this cycle; loads are ignored
        if (exch || do_pop) begin
            {flags_d, w_d} = top;
        end else begin
            if (load_w)     w_d     = alu_to_w;
            if (load_flags) flags_d = flags_in;
        end

        if (exch) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i + 1) == count_q) stk_d[i] = ctx;
            end
        end

        if (do_pop) count_d = count_q - CW'(1);

        if (do_push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_q) stk_d[i] = ctx;
            end
            count_d = count_q + CW'(1);
        end

        // Wrapping push on a full stack: oldest entry (index 0) falls off the bottom
        if (ev_ovf && (WRAP != 0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                stk_d[i] = stk_q[i + 1];
            end
            stk_d[DEPTH-1] = ctx;
        end

        ovf_d = ev_ovf || (ovf_q && !clr_err);
        unf_d = ev_unf || (unf_q && !clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q     <= '0;
            flags_q <= 3'b000;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_q     <= w_d;
            flags_q <= flags_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; the count alone decides which entries are valid
    always_ff @(posedge clk) begin
        stk_q <= stk_d;
    end

    assign w_accumulator_out = w_q;
    assign flags_out         = flags_q;
    assign stack_count       = count_q;
    assign stack_full        = (count_q == CW'(DEPTH));
    assign stack_empty       = (count_q == '0);
    assign overflow          = ovf_q;
    assign underflow         = unf_q;

endmodule

// File: tb/tb_cpu_w_context_stack.sv
// Bench for cpu_w_context_stack: three configurations driven in lockstep
// against a queue-based reference model, plus directed checks.
module tb_cpu_w_context_stack;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_w = 1'b0, load_flags = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [15:0] alu = '0;
    logic [2:0]  fin = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // a: W8 D2 no-wrap, b: W8 D2 wrap, c: W16 D4 wrap
    logic [7:0]  a_w, b_w;
    logic [15:0] c_w;
    logic [2:0]  a_f, b_f, c_f;
    logic [1:0]  a_cnt, b_cnt;
    logic [2:0]  c_cnt;
    logic        a_fu, a_em, a_ov, a_un;
    logic        b_fu, b_em, b_ov, b_un;
    logic        c_fu, c_em, c_ov, c_un;

    cpu_w_context_stack #(.WIDTH(8), .DEPTH(2), .WRAP(0)) u_a (
        .clk(clk), .rst(rst), .load_w(load_w), .alu_to_w(alu[7:0]),
        .load_flags(load_flags), .flags_in(fin), .push(push), .pop(pop),
        .clr_err(clr_err), .w_accumulator_out(a_w), .flags_out(a_f),
        .stack_count(a_cnt), .stack_full(a_fu), .stack_empty(a_em),
        .overflow(a_ov), .underflow(a_un));

    cpu_w_context_stack #(.WIDTH(8), .DEPTH(2), .WRAP(1)) u_b (
        .clk(clk), .rst(rst), .load_w(load_w), .alu_to_w(alu[7:0]),
        .load_flags(load_flags), .flags_in(fin), .push(push), .pop(pop),
        .clr_err(clr_err), .w_accumulator_out(b_w), .flags_out(b_f),
        .stack_count(b_cnt), .stack_full(b_fu), .stack_empty(b_em),
        .overflow(b_ov), .underflow(b_un));

    cpu_w_context_stack #(.WIDTH(16), .DEPTH(4), .WRAP(1)) u_c (
        .clk(clk), .rst(rst), .load_w(load_w), .alu_to_w(alu),
        .load_flags(load_flags), .flags_in(fin), .push(push), .pop(pop),
        .clr_err(clr_err), .w_accumulator_out(c_w), .flags_out(c_f),
        .stack_count(c_cnt), .stack_full(c_fu), .stack_empty(c_em),
        .overflow(c_ov), .underflow(c_un));

    // Reference model: one queue of {flags, W} per instance, back = top
    logic [18:0] mq [3][$];
    logic [15:0] m_w [3];
    logic [2:0]  m_f [3];
    bit          m_o [3];
    bit          m_u [3];
    int          md    [3] = '{2, 2, 4};
    bit          mwrap [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] mmask [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_w[k] = '0; m_f[k] = '0; m_o[k] = 0; m_u[k] = 0;
            mq[k].delete();
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [18:0] ctx, t;
            bit eo, eu, loads;
            ctx = {m_f[k], m_w[k]};
            eo = 0; eu = 0; loads = 1;
            if (push && pop && mq[k].size() > 0) begin
                t = mq[k][mq[k].size()-1];
                mq[k][mq[k].size()-1] = ctx;
                {m_f[k], m_w[k]} = t;
                loads = 0;
            end else if (pop && !push) begin
                if (mq[k].size() > 0) begin
                    t = mq[k].pop_back();
                    {m_f[k], m_w[k]} = t;
                    loads = 0;
                end else eu = 1;
            end else if (push) begin
                if (mq[k].size() < md[k]) mq[k].push_back(ctx);
                else begin
                    eo = 1;
                    if (mwrap[k]) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(ctx);
                    end
                end
            end
            if (loads) begin
                if (load_w)     m_w[k] = alu & mmask[k];
                if (load_flags) m_f[k] = fin;
            end
            m_o[k] = eo ? 1'b1 : (clr_err ? 1'b0 : m_o[k]);
            m_u[k] = eu ? 1'b1 : (clr_err ? 1'b0 : m_u[k]);
        end
    endtask

    task automatic cmp_inst(input string n, input int k, input logic [15:0] w, input logic [2:0] f,
                            input logic [2:0] cnt, input logic fu, input logic em,
                            input logic ov, input logic un);
        chk_val({n, "_w"},     32'(w),   32'(m_w[k]));
        chk_val({n, "_flags"}, 32'(f),   32'(m_f[k]));
        chk_val({n, "_count"}, 32'(cnt), 32'(mq[k].size()));
        chk_val({n, "_full"},  32'(fu),  32'(mq[k].size() == md[k]));
        chk_val({n, "_empty"}, 32'(em),  32'(mq[k].size() == 0));
        chk_val({n, "_ovf"},   32'(ov),  32'(m_o[k]));
        chk_val({n, "_unf"},   32'(un),  32'(m_u[k]));
    endtask

    task automatic compare_all();
        cmp_inst("a", 0, {8'h00, a_w}, a_f, {1'b0, a_cnt}, a_fu, a_em, a_ov, a_un);
        cmp_inst("b", 1, {8'h00, b_w}, b_f, {1'b0, b_cnt}, b_fu, b_em, b_ov, b_un);
        cmp_inst("c", 2, c_w, c_f, c_cnt, c_fu, c_em, c_ov, c_un);
    endtask

    // Inputs are driven on the falling edge; the model steps with the rising edge
    task automatic cyc(input logic lw, input logic [15:0] v, input logic lf, input logic [2:0] f,
                       input logic ps, input logic pp, input logic ce);
        load_w = lw; alu = v; load_flags = lf; fin = f; push = ps; pop = pp; clr_err = ce;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        load_w = 0; load_flags = 0; push = 0; pop = 0; clr_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        compare_all();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        chk_val("rst_w", 32'(a_w), 0);
        chk_val("rst_empty", 32'(a_em), 1);
        rst = 1'b1;

        // Load, then asynchronous reset mid-cycle
        cyc(1, 16'h00A5, 1, 3'b101, 0, 0, 0);
        chk_val("load_w", 32'(a_w), 32'hA5);
        chk_val("load_flags", 32'(a_f), 32'h5);
        rst = 1'b0;
        #1;
        chk_val("async_rst_w", 32'(a_w), 0);
        chk_val("async_rst_flags", 32'(a_f), 0);
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Push/pop with same-cycle loads
        cyc(1, 16'h0011, 1, 3'b001, 0, 0, 0);
        cyc(1, 16'h0022, 0, 3'b000, 1, 0, 0);
        chk_val("push_load_w", 32'(a_w), 32'h22);
        chk_val("push_count", 32'(a_cnt), 1);
        cyc(1, 16'h0033, 0, 3'b000, 0, 1, 0);
        chk_val("pop_w", 32'(a_w), 32'h11);
        chk_val("pop_flags", 32'(a_f), 1);
        chk_val("pop_count", 32'(a_cnt), 0);

        // Overflow / underflow with and without wrap
        do_reset();
        cyc(1, 16'h0001, 0, 3'b000, 0, 0, 0);
        cyc(1, 16'h0002, 0, 3'b000, 1, 0, 0);
        cyc(1, 16'h0003, 0, 3'b000, 1, 0, 0);
        cyc(0, 16'h0000, 0, 3'b000, 1, 0, 0);
        chk_val("nowrap_count", 32'(a_cnt), 2);
        chk_val("nowrap_ovf", 32'(a_ov), 1);
        chk_val("wrap_count", 32'(b_cnt), 2);
        chk_val("wrap_ovf", 32'(b_ov), 1);
        cyc(0, 16'h0000, 0, 3'b000, 0, 1, 0);
        chk_val("nowrap_pop1", 32'(a_w), 2);
        chk_val("wrap_pop1", 32'(b_w), 3);
        cyc(0, 16'h0000, 0, 3'b000, 0, 1, 0);
        chk_val("nowrap_pop2", 32'(a_w), 1);
        chk_val("wrap_pop2", 32'(b_w), 2);
        chk_val("wrap_empty", 32'(b_em), 1);
        cyc(0, 16'h0000, 0, 3'b000, 0, 1, 0);
        chk_val("unf_w_hold", 32'(a_w), 1);
        chk_val("unf_set", 32'(a_un), 1);
        cyc(0, 16'h0000, 0, 3'b000, 0, 0, 1);
        chk_val("clr_ovf", 32'(a_ov), 0);
        chk_val("clr_unf", 32'(a_un), 0);
        cyc(0, 16'h0000, 0, 3'b000, 0, 1, 1);
        chk_val("clr_vs_event", 32'(a_un), 1);

        // Exchange, then push+pop on an empty stack
        do_reset();
        cyc(1, 16'h0044, 0, 3'b000, 0, 0, 0);
        cyc(1, 16'h0055, 0, 3'b000, 1, 0, 0);
        cyc(1, 16'h0066, 1, 3'b111, 1, 1, 0);
        chk_val("xchg_w", 32'(a_w), 32'h44);
        chk_val("xchg_count", 32'(a_cnt), 1);
        cyc(0, 16'h0000, 0, 3'b000, 0, 1, 0);
        chk_val("xchg_top", 32'(a_w), 32'h55);
        cyc(0, 16'h0000, 0, 3'b000, 1, 1, 0);
        chk_val("empty_xchg_count", 32'(a_cnt), 1);
        chk_val("empty_xchg_unf", 32'(a_un), 0);

        // Random mix against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            else cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                     3'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
